// File: rtl/probe_pkg.sv
// Shared encodings for the LED debug probe: display modes, flag bit
// positions, freeze FSM states and the index-width helper.
package probe_pkg;

    localparam logic [1:0] MODE_BYTE  = 2'd0;
    localparam logic [1:0] MODE_FLAGS = 2'd1;
    localparam logic [1:0] MODE_SCAN  = 2'd2;

    localparam int ZF_BIT = 0;
    localparam int OF_BIT = 1;

    typedef enum logic {
        ST_LIVE,
        ST_FROZEN
    } frz_state_e;

    // Select fields stay at least one bit wide even for a single entry.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/probe_slice_sel.sv
// Combinational byte-slice extractor; an index past the last slice yields zero.
module probe_slice_sel
    import probe_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int LED_W  = 8,
    localparam int NB     = DATA_W / LED_W,
    localparam int IDX_W  = idx_w(NB)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [LED_W-1:0]  slice_o
);

    always_comb begin
        slice_o = '0;
        for (int b = 0; b < NB; b++) begin
            if (idx_i == IDX_W'(b)) slice_o = data_i[b*LED_W +: LED_W];
        end
    end

endmodule

// File: rtl/led_probe_mux.sv
// LED debug probe: manual byte, flags or auto-scanned byte view of one of
// N_CH datapath channels, with a freeze snapshot. LED output is registered.
module led_probe_mux
    import probe_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int LED_W    = 8,
    parameter  int N_CH     = 4,
    parameter  int SCAN_DIV = 24,
    localparam int NB       = DATA_W / LED_W,
    localparam int CH_W     = idx_w(N_CH),
    localparam int BYTE_W   = idx_w(NB)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH*2-1:0]      ch_flags,
    input  logic [CH_W-1:0]        sel_ch,
    input  logic [BYTE_W-1:0]      sel_byte,
    input  logic [1:0]             mode,
    input  logic                   freeze_pulse,
    output logic [LED_W-1:0]       LED,
    output logic [BYTE_W-1:0]      scan_idx,
    output logic                   frozen
);

    frz_state_e          state_q, state_d;
    logic [DATA_W-1:0]   shadow_data_q, shadow_data_d;
    logic [1:0]          shadow_flags_q, shadow_flags_d;
    logic [SCAN_DIV-1:0] presc_q, presc_d;
    logic [BYTE_W-1:0]   scan_idx_q, scan_idx_d;
    logic                scan_act_q, scan_act_d;
    logic [LED_W-1:0]    led_q, led_d;

    logic [DATA_W-1:0]   live_data, src_data;
    logic [1:0]          live_flags, src_flags;
    logic [LED_W-1:0]    man_slice, scan_slice;

    // An out-of-range channel reads as zero, so a freeze on it captures zeros.
    always_comb begin
        live_data  = '0;
        live_flags = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (sel_ch == CH_W'(c)) begin
                live_data  = ch_data[c*DATA_W +: DATA_W];
                live_flags = ch_flags[c*2 +: 2];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        shadow_data_d  = shadow_data_q;
        shadow_flags_d = shadow_flags_q;
        if (freeze_pulse) begin
            case (state_q)
                ST_LIVE: begin
                    state_d        = ST_FROZEN;
                    shadow_data_d  = live_data;
                    shadow_flags_d = live_flags;
                end
                ST_FROZEN: state_d = ST_LIVE;
            endcase
        end
    end

    assign frozen    = (state_q == ST_FROZEN);
    assign src_data  = frozen ? shadow_data_q  : live_data;
    assign src_flags = frozen ? shadow_flags_q : live_flags;

    // The entry cycle only arms the scan; counting starts on the next cycle.
    always_comb begin
        scan_act_d = (mode == MODE_SCAN);
        presc_d    = '0;
        scan_idx_d = '0;
        if (mode == MODE_SCAN && scan_act_q) begin
            presc_d    = presc_q + SCAN_DIV'(1);
            scan_idx_d = scan_idx_q;
            if (presc_q == '1) begin
                scan_idx_d = (scan_idx_q == BYTE_W'(NB - 1)) ? '0
                                                             : scan_idx_q + BYTE_W'(1);
            end
        end
    end

    probe_slice_sel #(.DATA_W(DATA_W), .LED_W(LED_W)) u_man_sel (
        .data_i  (src_data),
        .idx_i   (sel_byte),
        .slice_o (man_slice)
    );

    probe_slice_sel #(.DATA_W(DATA_W), .LED_W(LED_W)) u_scan_sel (
        .data_i  (src_data),
        .idx_i   (scan_idx_q),
        .slice_o (scan_slice)
    );

    always_comb begin
        led_d = '0;
        case (mode)
            MODE_BYTE: led_d = man_slice;
            MODE_SCAN: led_d = scan_slice;
            default: begin
                led_d[ZF_BIT] = src_flags[ZF_BIT];
                led_d[OF_BIT] = src_flags[OF_BIT];
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q        <= ST_LIVE;
            shadow_data_q  <= '0;
            shadow_flags_q <= '0;
            presc_q        <= '0;
            scan_idx_q     <= '0;
            scan_act_q     <= 1'b0;
            led_q          <= '0;
        end else begin
            state_q        <= state_d;
            shadow_data_q  <= shadow_data_d;
            shadow_flags_q <= shadow_flags_d;
            presc_q        <= presc_d;
            scan_idx_q     <= scan_idx_d;
            scan_act_q     <= scan_act_d;
            led_q          <= led_d;
        end
    end

    assign LED      = led_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_led_probe_mux.sv
// Bench for led_probe_mux: cycle-level reference model plus directed and
// random steps; a second 3-channel instance covers the invalid-channel case.
module tb_led_probe_mux;

    localparam int N_CH     = 4;
    localparam int SCAN_DIV = 2;
    localparam int NB       = 4;
    localparam int STEP     = 1 << SCAN_DIV;

    logic         CLK = 1'b0;
    logic         RST;
    logic [127:0] ch_data;
    logic [7:0]   ch_flags;
    logic [1:0]   sel_ch, sel_byte, mode;
    logic         freeze_pulse;
    logic [7:0]   LED, LED3;
    logic [1:0]   scan_idx, scan_idx3;
    logic         frozen, frozen3;

    always #5 CLK = ~CLK;

    led_probe_mux #(.DATA_W(32), .LED_W(8), .N_CH(N_CH), .SCAN_DIV(SCAN_DIV)) dut (
        .CLK(CLK), .RST(RST), .ch_data(ch_data), .ch_flags(ch_flags),
        .sel_ch(sel_ch), .sel_byte(sel_byte), .mode(mode), .freeze_pulse(freeze_pulse),
        .LED(LED), .scan_idx(scan_idx), .frozen(frozen)
    );

    led_probe_mux #(.DATA_W(32), .LED_W(8), .N_CH(3), .SCAN_DIV(SCAN_DIV)) dut3 (
        .CLK(CLK), .RST(RST), .ch_data(ch_data[95:0]), .ch_flags(ch_flags[5:0]),
        .sel_ch(sel_ch), .sel_byte(sel_byte), .mode(mode), .freeze_pulse(freeze_pulse),
        .LED(LED3), .scan_idx(scan_idx3), .frozen(frozen3)
    );

    // Reference state: m_n counts edges spent in auto-scan (-1 when outside it).
    bit          m_frozen;
    logic [31:0] m_sh_data;
    logic [1:0]  m_sh_flags;
    int          m_n = -1;
    logic [7:0]  m_led;
    int          n_checks = 0;
    int          n_err = 0;

    function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
        return 8'((d >> (8 * i)) & 32'hFF);
    endfunction

    function automatic int exp_idx();
        return (m_n < 0) ? 0 : (m_n / STEP) % NB;
    endfunction

    task automatic model_edge();
        logic [31:0] live_d, src_d;
        logic [1:0]  live_f, src_f;
        if (!RST) begin
            m_frozen = 0; m_sh_data = 0; m_sh_flags = 0; m_n = -1; m_led = 0;
            return;
        end
        live_d = 32'(ch_data >> (32 * sel_ch));
        live_f = 2'(ch_flags >> (2 * sel_ch));
        src_d  = m_frozen ? m_sh_data  : live_d;
        src_f  = m_frozen ? m_sh_flags : live_f;
        case (mode)
            2'd0:    m_led = byte_of(src_d, int'(sel_byte));
            2'd2:    m_led = byte_of(src_d, exp_idx());
            default: m_led = {6'b0, src_f};
        endcase
        if (freeze_pulse) begin
            if (!m_frozen) begin
                m_sh_data  = live_d;
                m_sh_flags = live_f;
            end
            m_frozen = !m_frozen;
        end
        m_n = (mode == 2'd2) ? m_n + 1 : -1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        chk("led", 32'(LED), 32'(m_led));
        chk("frozen", 32'(frozen), 32'(m_frozen));
        chk("scan_idx", 32'(scan_idx), exp_idx());
    endtask

    task automatic rand_inputs(input int pfrz);
        ch_data      = {$urandom, $urandom, $urandom, $urandom};
        ch_flags     = 8'($urandom);
        sel_ch       = 2'($urandom);
        sel_byte     = 2'($urandom);
        mode         = 2'($urandom);
        freeze_pulse = ($urandom_range(0, 99) < pfrz);
    endtask

    task automatic unfreeze();
        if (m_frozen) begin
            freeze_pulse = 1'b1;
            tick();
            freeze_pulse = 1'b0;
        end
    endtask

    initial begin
        // Reset with random inputs
        RST = 1'b0;
        rand_inputs(50);
        for (int i = 0; i < 3; i++) begin
            tick();
            rand_inputs(50);
        end
        chk("rst_led", 32'(LED), 0);
        chk("rst_frozen", 32'(frozen), 0);
        chk("rst_scan", 32'(scan_idx), 0);
        RST = 1'b1;

        // Random mix of all modes
        for (int i = 0; i < 60; i++) begin
            rand_inputs(12);
            tick();
        end

        // Manual byte view
        freeze_pulse = 1'b0;
        unfreeze();
        ch_data[95:64] = 32'hDEADBEEF;
        sel_ch = 2'd2;
        mode   = 2'd0;
        for (int b = 0; b < 4; b++) begin
            logic [31:0] ref_word;
            ref_word = 32'hDEADBEEF;
            sel_byte = 2'(b);
            tick();
            chk("manual", 32'(LED), 32'(ref_word[b*8 +: 8]));
        end

        // Flags view, including reserved mode 3
        ch_flags[3:2] = 2'b10;
        sel_ch = 2'd1;
        mode   = 2'd1;
        tick();
        chk("flags", 32'(LED), 32'h02);
        mode = 2'd3;
        tick();
        chk("flags_m3", 32'(LED), 32'h02);

        // Auto-scan from manual mode
        ch_data[31:0] = 32'h44332211;
        sel_ch = 2'd0;
        mode   = 2'd0;
        tick();
        mode = 2'd2;
        for (int k = 0; k < 22; k++) begin
            int prev_idx;
            prev_idx = (k < 1) ? 0 : ((k - 1) / STEP) % NB;
            tick();
            chk("scan_led", 32'(LED), 32'h11 * (prev_idx + 1));
            chk("scan_step", 32'(scan_idx), (k / STEP) % NB);
        end

        // Freeze snapshot survives data and channel changes
        mode = 2'd0;
        sel_byte = 2'd0;
        ch_data[127:96] = 32'h12345678;
        sel_ch = 2'd3;
        tick();
        freeze_pulse = 1'b1;
        tick();
        chk("frz_set", 32'(frozen), 1);
        freeze_pulse = 1'b0;
        ch_data[127:96] = 32'h0;
        ch_data[31:0] = 32'hAABBCCDD;
        sel_ch = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_hold", 32'(LED), 32'h78);
        end
        freeze_pulse = 1'b1;
        tick();
        freeze_pulse = 1'b0;
        tick();
        chk("frz_release", 32'(LED), 32'hDD);

        // Invalid channel on the 3-channel instance
        RST = 1'b0;
        tick();
        RST = 1'b1;
        ch_data[31:0] = 32'h0000005A;
        ch_data[95:32] = {$urandom | 32'h1, $urandom | 32'h1};
        ch_flags = 8'hFF;
        sel_ch = 2'd3;
        sel_byte = 2'd1;
        mode = 2'd0;
        tick();
        chk("inv_manual", 32'(LED3), 0);
        mode = 2'd1;
        tick();
        chk("inv_flags", 32'(LED3), 0);
        freeze_pulse = 1'b1;
        tick();
        chk("inv_frz", 32'(frozen3), 1);
        freeze_pulse = 1'b0;
        sel_ch = 2'd0;
        sel_byte = 2'd0;
        mode = 2'd0;
        tick();
        tick();
        chk("inv_snap", 32'(LED3), 0);
        freeze_pulse = 1'b1;
        tick();
        freeze_pulse = 1'b0;
        tick();
        chk("inv_live", 32'(LED3), 32'h5A);
        chk("inv_scan", 32'(scan_idx3), 0);

        // Reset while frozen in the middle of a scan
        ch_data = {$urandom, $urandom, $urandom, $urandom};
        mode = 2'd2;
        freeze_pulse = 1'b1;
        tick();
        freeze_pulse = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        RST = 1'b0;
        tick();
        chk("rst_mid_frozen", 32'(frozen), 0);
        chk("rst_mid_scan", 32'(scan_idx), 0);
        chk("rst_mid_led", 32'(LED), 0);
        RST = 1'b1;

        // Long scan with random data and freezes, then a broad random run
        for (int i = 0; i < 40; i++) begin
            rand_inputs(8);
            mode = 2'd2;
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            rand_inputs(15);
            if ($urandom_range(0, 39) == 0) mode = 2'd2;
            RST = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
